gtech_ld_bank_ctrl: RTL and testbench
=====================================

Name: gtech_ld_bank_ctrl

Overview:
- Write sequencer and arbiter for a bank of NENT GTECH_LD4 latch words, each DW bits wide.
- Each word shares one low-active gate (GN) per entry. One common low-active clear (CD) drives every latch CD pin.
- Two requesters share the single bank write path through round-robin arbitration.
- Each write or clear runs as a glitch-free gate window: data setup, gate open, data hold. This keeps the latch D input stable across the whole transparent phase.

Parameters:
- DW, 8, data width of one latch word.
- NENT, 4, number of latch words in the bank.
- AW, 2, address width; NENT <= 2**AW.
- PULSE_CYC, 2, number of CP cycles the gate or clear is held active; legal range 1..15.

Ports:
- CP  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous active-high reset.
- REQ0  in  1  requester 0 operation request; level, held until DONE0.
- CLR0  in  1  requester 0 op type: 1 = clear all, 0 = write.
- ADDR0  in  AW  requester 0 write address.
- DATA0  in  DW  requester 0 write data.
- DONE0  out  1  one-cycle completion pulse to requester 0.
- REQ1, CLR1, ADDR1, DATA1, DONE1: same as the requester 0 ports, for requester 1.
- LD_D  out  DW  data bus to all latch D pins.
- LD_GN  out  NENT  per-entry gate, active low.
- LD_CD  out  1  bank clear, active low.
- BUSY  out  1  high in every state except IDLE.
- OWNER  out  1  id of the requester currently being served.
- ERR  out  1  one-cycle pulse when a write address is >= NENT.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, LD_GN all 1, LD_CD 1, LD_D 0, DONE0/DONE1 0, BUSY 0, OWNER 0, ERR 0, round-robin pointer 0 (requester 0 favoured).
- RST is sampled on the clock edge only.
- Reset mid-operation returns to IDLE on that edge with all gates closed. Reset does not assert LD_CD, so latch contents are preserved. The interrupted requester gets no DONE.

FSM states: IDLE, SETUP, OPEN, HOLD.

IDLE:
- If any REQ is high, accept one request. The op fields (CLR, ADDR, DATA) are captured in internal registers.
- The next state is SETUP.

SETUP (1 cycle):
- LD_D drives the captured data; all gates stay high.

OPEN (PULSE_CYC cycles, counted with an internal counter):
- Write: LD_GN[addr] = 0; all other gates stay 1.
- Clear: LD_CD = 0; all gates stay 1.

HOLD (1 cycle):
- Gates and CD are back to inactive; LD_D still holds the data.
- DONEx pulses for the owner.
- ERR pulses if this was a write to an out-of-range address.
- The next state is IDLE.

Arbitration:
- Only one request is served at a time.
- If both requests are present in IDLE, grant goes to the pointer value. After any grant the pointer is set to the other requester.
- A single request is granted regardless of the pointer.
- OWNER updates on accept and holds until the next accept.

Latency and handshake:
- Accept edge = T. SETUP runs at T+1, OPEN at T+2..T+1+PULSE_CYC, HOLD/DONE at T+2+PULSE_CYC.
- Back-to-back operations: the next accept happens in IDLE at T+3+PULSE_CYC, so one op takes PULSE_CYC+3 cycles.
- A requester that is still asserting REQ in the cycle after its DONE is treated as a new request.
- REQ dropped after accept: the operation still completes and DONE still pulses.
- Op fields changing after accept are ignored.

Boundary cases:
- Out-of-range write address: the full FSM sequence runs with no gate asserted; DONE and ERR both pulse.
- Clear ops ignore ADDR and DATA; LD_D keeps its previous value.
- LD_GN and LD_CD are never active in the same cycle.
- No gate is ever active in SETUP, HOLD or IDLE.
- LD_D never changes during OPEN.

Test Plan:
- Reset then idle: RST high for 2 cycles -> LD_GN=4'b1111, LD_CD=1, LD_D=0, BUSY=0, DONE0/DONE1=0. Holds for 10 cycles with no REQ.
- Single write: REQ0=1, ADDR0=2, DATA0=8'hA5 at T (PULSE_CYC=2) -> LD_D=8'hA5 from T+1. LD_GN=4'b1011 exactly at T+2 and T+3. DONE0 pulses at T+4. The model latch at entry 2 holds 8'hA5.
- Contention: REQ0 and REQ1 both high continuously, writes to addresses 0 and 1 -> grants alternate 0,1,0,1 after reset, OWNER toggles, and each DONE is spaced 5 cycles apart.
- Clear: REQ1=1, CLR1=1 -> LD_CD=0 for exactly 2 cycles, LD_GN stays 4'b1111. DONE1 pulses and all model latches read 0.
- Bad address: NENT=3, REQ0 with ADDR0=3 -> no LD_GN bit goes low. DONE0 and ERR pulse together at T+4.
- Reset mid-op: assert RST during the first OPEN cycle -> on the next edge LD_GN=4'b1111, LD_CD=1, state IDLE, no DONE. The latch keeps data written in the partial window.

Source files
------------

// File: rtl/gtech_ld_bank_ctrl.sv
// Write sequencer and round-robin arbiter for a bank of GTECH_LD4 latch words.
// Each write or clear runs as a setup / open / hold window, so D is stable whenever a gate is transparent.
module gtech_ld_bank_ctrl #(
  parameter int DW        = 8,
  parameter int NENT      = 4,
  parameter int AW        = 2,
  parameter int PULSE_CYC = 2
) (
  input  logic            CP,
  input  logic            RST,
  input  logic            REQ0,
  input  logic            CLR0,
  input  logic [AW-1:0]   ADDR0,
  input  logic [DW-1:0]   DATA0,
  output logic            DONE0,
  input  logic            REQ1,
  input  logic            CLR1,
  input  logic [AW-1:0]   ADDR1,
  input  logic [DW-1:0]   DATA1,
  output logic            DONE1,
  output logic [DW-1:0]   LD_D,
  output logic [NENT-1:0] LD_GN,
  output logic            LD_CD,
  output logic            BUSY,
  output logic            OWNER,
  output logic            ERR
);

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          rr_ptr;
  logic          op_clr;
  logic [AW-1:0] op_addr;

  logic          grant;
  logic          sel_clr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          bad_addr;

  // A lone request wins outright; the pointer only breaks ties.
  always_comb begin
    grant    = (REQ0 && REQ1) ? rr_ptr : REQ1;
    sel_clr  = grant ? CLR1  : CLR0;
    sel_addr = grant ? ADDR1 : ADDR0;
    sel_data = grant ? DATA1 : DATA0;
    bad_addr = ({1'b0, op_addr} >= (AW+1)'(NENT));
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      rr_ptr  <= 1'b0;
      op_clr  <= 1'b0;
      op_addr <= '0;
      LD_D    <= '0;
      LD_GN   <= '1;
      LD_CD   <= 1'b1;
      DONE0   <= 1'b0;
      DONE1   <= 1'b0;
      BUSY    <= 1'b0;
      OWNER   <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            state   <= SETUP;
            BUSY    <= 1'b1;
            OWNER   <= grant;
            rr_ptr  <= ~grant;
            op_clr  <= sel_clr;
            op_addr <= sel_addr;
            // A clear leaves the data bus where it was.
            if (!sel_clr) LD_D <= sel_data;
          end
        end
        SETUP: begin
          state <= OPEN;
          cnt   <= 4'(PULSE_CYC - 1);
          if (op_clr) begin
            LD_CD <= 1'b0;
          end else begin
            // An out-of-range address matches no entry, so no gate opens.
            for (int i = 0; i < NENT; i++) LD_GN[i] <= (op_addr != AW'(i));
          end
        end
        OPEN: begin
          if (cnt == 4'd0) begin
            state <= HOLD;
            LD_GN <= '1;
            LD_CD <= 1'b1;
            if (OWNER) DONE1 <= 1'b1;
            else       DONE0 <= 1'b1;
            ERR   <= !op_clr && bad_addr;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gtech_ld_bank_ctrl.sv
// Directed bench for gtech_ld_bank_ctrl: a cycle table for single ops plus hand sequences
// for contention, an out-of-range address (NENT=3 instance) and reset mid-operation.
module tb_gtech_ld_bank_ctrl;

  logic       CP = 1'b0;
  logic       RST;
  logic       req0, clr0, req1, clr1;
  logic [1:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       done0, done1, busy, owner, err, ld_cd;
  logic [7:0] ld_d;
  logic [3:0] ld_gn;

  logic       b_req0;
  logic [1:0] b_addr0;
  logic [7:0] b_data0;
  logic       b_done0, b_done1, b_busy, b_owner, b_err, b_cd;
  logic [7:0] b_d;
  logic [2:0] b_gn;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] lat [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  always #5 CP = ~CP;

  gtech_ld_bank_ctrl #(.DW(8), .NENT(4), .AW(2), .PULSE_CYC(2)) dut (
    .CP(CP), .RST(RST),
    .REQ0(req0), .CLR0(clr0), .ADDR0(addr0), .DATA0(data0), .DONE0(done0),
    .REQ1(req1), .CLR1(clr1), .ADDR1(addr1), .DATA1(data1), .DONE1(done1),
    .LD_D(ld_d), .LD_GN(ld_gn), .LD_CD(ld_cd), .BUSY(busy), .OWNER(owner), .ERR(err)
  );

  gtech_ld_bank_ctrl #(.DW(8), .NENT(3), .AW(2), .PULSE_CYC(2)) dut_bad (
    .CP(CP), .RST(RST),
    .REQ0(b_req0), .CLR0(1'b0), .ADDR0(b_addr0), .DATA0(b_data0), .DONE0(b_done0),
    .REQ1(1'b0), .CLR1(1'b0), .ADDR1(2'd0), .DATA1(8'h00), .DONE1(b_done1),
    .LD_D(b_d), .LD_GN(b_gn), .LD_CD(b_cd), .BUSY(b_busy), .OWNER(b_owner), .ERR(b_err)
  );

  // Behavioural model of the latch bank, sampled mid-cycle while the gates are stable.
  always @(negedge CP) begin
    for (int i = 0; i < 4; i++) if (!ld_gn[i]) lat[i] = ld_d;
    if (!ld_cd) for (int i = 0; i < 4; i++) lat[i] = 8'h00;
  end

  typedef struct {
    logic       rst;
    logic       req0, clr0;
    logic [1:0] addr0;
    logic [7:0] data0;
    logic       req1, clr1;
    logic [1:0] addr1;
    logic [7:0] data1;
    logic [3:0] gn;
    logic       cd;
    logic [7:0] d;
    logic       done0, done1, busy, owner, err;
    logic       lat_en;
    int         lat_idx;
    logic [7:0] lat_val;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic r0, input logic c0, input logic [1:0] a0,
                         input logic [7:0] d0, input logic r1, input logic c1, input logic [1:0] a1,
                         input logic [7:0] d1, input logic [3:0] gn, input logic cd, input logic [7:0] d,
                         input logic dn0, input logic dn1, input logic bz, input logic ow, input logic er,
                         input logic le, input int li, input logic [7:0] lv);
    vec_t v;
    v.rst = rst; v.req0 = r0; v.clr0 = c0; v.addr0 = a0; v.data0 = d0;
    v.req1 = r1; v.clr1 = c1; v.addr1 = a1; v.data1 = d1;
    v.gn = gn; v.cd = cd; v.d = d; v.done0 = dn0; v.done1 = dn1;
    v.busy = bz; v.owner = ow; v.err = er;
    v.lat_en = le; v.lat_idx = li; v.lat_val = lv;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    RST = v.rst;
    req0 = v.req0; clr0 = v.clr0; addr0 = v.addr0; data0 = v.data0;
    req1 = v.req1; clr1 = v.clr1; addr1 = v.addr1; data1 = v.data1;
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  initial begin
    int n_done;
    int done_cyc[$];
    logic done_own[$];
    int cyc;

    RST = 1'b1;
    req0 = 1'b0; clr0 = 1'b0; addr0 = 2'd0; data0 = 8'h00;
    req1 = 1'b0; clr1 = 1'b0; addr1 = 2'd0; data1 = 8'h00;
    b_req0 = 1'b0; b_addr0 = 2'd0; b_data0 = 8'h00;

    // Reset for two cycles, then idle for ten with no request.
    tick();
    tick();
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("idle_gn", ld_gn, 4'hF);
      checkOutput("idle_cd", ld_cd, 1'b1);
      checkOutput("idle_d", ld_d, 8'h00);
      checkOutput("idle_busy", busy, 1'b0);
      checkOutput("idle_done", {done0, done1}, 2'b00);
    end

    //      rst r0 c0 a0 d0     r1 c1 a1 d1     gn     cd d      dn0 dn1 bz ow er  le li lv
    add_vec(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'hF, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add_vec(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'hF, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add_vec(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'hF, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add_vec(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'hF, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add_vec(0, 1, 0, 2, 8'hA5, 0, 0, 0, 8'h00, 4'hF, 1, 8'hA5, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    add_vec(0, 1, 0, 2, 8'hA5, 0, 0, 0, 8'h00, 4'hB, 1, 8'hA5, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    add_vec(0, 1, 0, 2, 8'hA5, 0, 0, 0, 8'h00, 4'hB, 1, 8'hA5, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    add_vec(0, 1, 0, 2, 8'hA5, 0, 0, 0, 8'h00, 4'hF, 1, 8'hA5, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add_vec(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'hF, 1, 8'hA5, 0, 0, 0, 0, 0, 1, 2, 8'hA5);
    add_vec(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h33, 4'hF, 1, 8'hA5, 0, 0, 1, 1, 0, 0, 0, 8'h00);
    add_vec(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h33, 4'hF, 0, 8'hA5, 0, 0, 1, 1, 0, 0, 0, 8'h00);
    add_vec(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h33, 4'hF, 0, 8'hA5, 0, 0, 1, 1, 0, 0, 0, 8'h00);
    add_vec(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h33, 4'hF, 1, 8'hA5, 0, 1, 1, 1, 0, 0, 0, 8'h00);
    add_vec(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'hF, 1, 8'hA5, 0, 0, 0, 1, 0, 1, 2, 8'h00);
    add_vec(0, 1, 0, 1, 8'h3C, 0, 0, 0, 8'h00, 4'hF, 1, 8'h3C, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    add_vec(0, 1, 0, 1, 8'h3C, 0, 0, 0, 8'h00, 4'hD, 1, 8'h3C, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    add_vec(0, 1, 0, 1, 8'h3C, 0, 0, 0, 8'h00, 4'hD, 1, 8'h3C, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    add_vec(0, 1, 0, 1, 8'h3C, 0, 0, 0, 8'h00, 4'hF, 1, 8'h3C, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add_vec(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'hF, 1, 8'h3C, 0, 0, 0, 0, 0, 1, 1, 8'h3C);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      tick();
      checkOutput($sformatf("v%0d_gn", k), ld_gn, vecs[k].gn);
      checkOutput($sformatf("v%0d_cd", k), ld_cd, vecs[k].cd);
      checkOutput($sformatf("v%0d_d", k), ld_d, vecs[k].d);
      checkOutput($sformatf("v%0d_done", k), {done0, done1}, {vecs[k].done0, vecs[k].done1});
      checkOutput($sformatf("v%0d_busy", k), busy, vecs[k].busy);
      checkOutput($sformatf("v%0d_owner", k), owner, vecs[k].owner);
      checkOutput($sformatf("v%0d_err", k), err, vecs[k].err);
      if (vecs[k].lat_en)
        checkOutput($sformatf("v%0d_latch", k), lat[vecs[k].lat_idx], vecs[k].lat_val);
    end

    // Contention: both requesters hold REQ; grants alternate starting at requester 0.
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    req0 = 1'b1; clr0 = 1'b0; addr0 = 2'd0; data0 = 8'h11;
    req1 = 1'b1; clr1 = 1'b0; addr1 = 2'd1; data1 = 8'h22;
    n_done = 0;
    cyc = 0;
    while (cyc < 40 && n_done < 4) begin
      tick();
      cyc++;
      if (done0 || done1) begin
        checkOutput("cont_done_onehot", {done0, done1} == 2'b11, 1'b0);
        checkOutput("cont_owner_at_done", owner, done1);
        done_cyc.push_back(cyc);
        done_own.push_back(done1);
        n_done++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("cont_done_count", n_done, 4);
    foreach (done_own[k]) checkOutput($sformatf("cont_grant%0d", k), done_own[k], k % 2);
    for (int k = 1; k < done_cyc.size(); k++)
      checkOutput($sformatf("cont_spacing%0d", k), done_cyc[k] - done_cyc[k-1], 5);
    tick();
    tick();
    checkOutput("cont_busy_after", busy, 1'b0);
    checkOutput("cont_lat0", lat[0], 8'h11);
    checkOutput("cont_lat1", lat[1], 8'h22);

    // Out-of-range write on the three-entry instance: no gate, DONE and ERR together.
    b_req0 = 1'b1; b_addr0 = 2'd3; b_data0 = 8'h5A;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checkOutput($sformatf("bad_gn_e%0d", e), b_gn, 3'b111);
      checkOutput($sformatf("bad_done_e%0d", e), b_done0, (e == 4) ? 1'b1 : 1'b0);
      checkOutput($sformatf("bad_err_e%0d", e), b_err, (e == 4) ? 1'b1 : 1'b0);
    end
    b_req0 = 1'b0;
    tick();
    checkOutput("bad_err_after", b_err, 1'b0);

    // Reset during the first OPEN cycle: gates close, no DONE, partial write survives.
    req0 = 1'b1; addr0 = 2'd3; data0 = 8'hC3;
    tick();
    tick();
    checkOutput("rst_mid_open_gn", ld_gn, 4'h7);
    RST = 1'b1;
    req0 = 1'b0;
    tick();
    checkOutput("rst_mid_gn", ld_gn, 4'hF);
    checkOutput("rst_mid_cd", ld_cd, 1'b1);
    checkOutput("rst_mid_busy", busy, 1'b0);
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("rst_mid_no_done", done0, 1'b0);
      checkOutput("rst_mid_idle", busy, 1'b0);
    end
    checkOutput("rst_mid_lat3", lat[3], 8'hC3);
    checkOutput("rst_mid_lat0", lat[0], 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
